// File: rtl/mem_access.sv
// Memory-access stage: one instruction per handshake, at most one data-memory
// access in flight, results delivered as a registered one-cycle MEM/WB bundle.
module mem_access #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid_i,
    output logic              mem_ready_o,
    input  logic [XLEN-1:0]   ex_alu_res_i,
    input  logic [XLEN-1:0]   ex_store_data_i,
    input  logic [XLEN-1:0]   ex_instr_imm_i,
    input  logic [XLEN-1:0]   ex_pc_val_i,
    input  logic [1:0]        ex_rf_wr_data_src_i,
    input  logic              ex_rf_wr_en_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_mem_rd_i,
    input  logic              ex_mem_wr_i,
    input  logic [1:0]        ex_mem_size_i,
    input  logic              ex_mem_zext_i,
    output logic              dmem_req_o,
    output logic              dmem_wr_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [7:0]        dmem_byte_en_o,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              wb_valid_o,
    output logic [XLEN-1:0]   wb_alu_res_o,
    output logic [XLEN-1:0]   wb_data_mem_rd_o,
    output logic [XLEN-1:0]   wb_instr_imm_o,
    output logic [XLEN-1:0]   wb_pc_val_o,
    output logic [1:0]        wb_rf_wr_data_src_o,
    output logic              wb_rf_wr_en_o,
    output logic [REG_AW-1:0] wb_rd_addr_o,
    output logic              wb_misaligned_o,
    output logic              dbg_state_o
);

    // Handshake: ex_* are sampled only on a cycle where ex_valid_i && mem_ready_o;
    // dmem_req_o is held with stable fields until dmem_rvalid_i is seen in WAIT.
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t state_q, state_d;

    logic            accept, is_mem, misaligned, start_mem, finish_mem;
    logic [7:0]      lane_en;
    logic [XLEN-1:0] lane_wdata, load_shifted, load_ext;

    logic [XLEN-1:0]   p_alu_res, p_instr_imm, p_pc_val;
    logic [1:0]        p_src, p_size;
    logic              p_rf_wr_en, p_load, p_zext;
    logic [REG_AW-1:0] p_rd_addr;
    logic              wb_rf_wr_en_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_mem) state_d = WAIT;
            WAIT:    if (dmem_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        mem_ready_o = (state_q == IDLE) && !reset;
        accept      = ex_valid_i && mem_ready_o;
        start_mem   = accept && is_mem && !misaligned;
        finish_mem  = (state_q == WAIT) && dmem_rvalid_i;
        dbg_state_o = (state_q == WAIT);
    end

    // ---------------- Request decode ----------------
    always_comb begin
        is_mem     = ex_mem_rd_i || ex_mem_wr_i;
        misaligned = 1'b0;
        lane_en    = 8'h00;
        case (ex_mem_size_i)
            2'd0: begin misaligned = 1'b0;                  lane_en = 8'h01 << ex_alu_res_i[2:0]; end
            2'd1: begin misaligned = ex_alu_res_i[0];       lane_en = 8'h03 << ex_alu_res_i[2:0]; end
            2'd2: begin misaligned = |ex_alu_res_i[1:0];    lane_en = 8'h0F << ex_alu_res_i[2:0]; end
            default: begin misaligned = |ex_alu_res_i[2:0]; lane_en = 8'hFF; end
        endcase
        lane_wdata = ex_store_data_i << {ex_alu_res_i[2:0], 3'b000};
    end

    // ---------------- Load alignment and extension ----------------
    always_comb begin
        load_shifted = dmem_rdata_i >> {dmem_addr_o[2:0], 3'b000};
        load_ext     = '0;
        case (p_size)
            2'd0: load_ext = p_zext ? {{(XLEN-8){1'b0}}, load_shifted[7:0]}
                                    : {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
            2'd1: load_ext = p_zext ? {{(XLEN-16){1'b0}}, load_shifted[15:0]}
                                    : {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
            2'd2: load_ext = p_zext ? {{(XLEN-32){1'b0}}, load_shifted[31:0]}
                                    : {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
            default: load_ext = load_shifted;
        endcase
    end

    // ---------------- Memory request registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req_o     <= 1'b0;
            dmem_wr_o      <= 1'b0;
            dmem_addr_o    <= '0;
            dmem_wdata_o   <= '0;
            dmem_byte_en_o <= 8'h00;
        end else if (start_mem) begin
            dmem_req_o     <= 1'b1;
            dmem_wr_o      <= ex_mem_wr_i;
            dmem_addr_o    <= ex_alu_res_i;
            dmem_wdata_o   <= lane_wdata;
            dmem_byte_en_o <= lane_en;
        end else if (finish_mem) begin
            dmem_req_o     <= 1'b0;
        end
    end

    // Bundle fields parked here while the access is outstanding, so the visible
    // wb payload keeps its previous value until the access completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_alu_res   <= '0;
            p_instr_imm <= '0;
            p_pc_val    <= '0;
            p_src       <= 2'd0;
            p_size      <= 2'd0;
            p_rf_wr_en  <= 1'b0;
            p_load      <= 1'b0;
            p_zext      <= 1'b0;
            p_rd_addr   <= '0;
        end else if (start_mem) begin
            p_alu_res   <= ex_alu_res_i;
            p_instr_imm <= ex_instr_imm_i;
            p_pc_val    <= ex_pc_val_i;
            p_src       <= ex_rf_wr_data_src_i;
            p_size      <= ex_mem_size_i;
            p_rf_wr_en  <= ex_rf_wr_en_i;
            p_load      <= ex_mem_rd_i;
            p_zext      <= ex_mem_zext_i;
            p_rd_addr   <= ex_rd_addr_i;
        end
    end

    // ---------------- MEM/WB bundle ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_o          <= 1'b0;
            wb_alu_res_o        <= '0;
            wb_data_mem_rd_o    <= '0;
            wb_instr_imm_o      <= '0;
            wb_pc_val_o         <= '0;
            wb_rf_wr_data_src_o <= 2'd0;
            wb_rf_wr_en_q       <= 1'b0;
            wb_rd_addr_o        <= '0;
            wb_misaligned_o     <= 1'b0;
        end else begin
            wb_valid_o <= (accept && !start_mem) || finish_mem;
            if (accept && !start_mem) begin
                wb_alu_res_o        <= ex_alu_res_i;
                wb_data_mem_rd_o    <= '0;
                wb_instr_imm_o      <= ex_instr_imm_i;
                wb_pc_val_o         <= ex_pc_val_i;
                wb_rf_wr_data_src_o <= ex_rf_wr_data_src_i;
                wb_rf_wr_en_q       <= ex_rf_wr_en_i;
                wb_rd_addr_o        <= ex_rd_addr_i;
                wb_misaligned_o     <= is_mem && misaligned;
            end else if (finish_mem) begin
                wb_alu_res_o        <= p_alu_res;
                wb_data_mem_rd_o    <= p_load ? load_ext : '0;
                wb_instr_imm_o      <= p_instr_imm;
                wb_pc_val_o         <= p_pc_val;
                wb_rf_wr_data_src_o <= p_src;
                wb_rf_wr_en_q       <= p_rf_wr_en;
                wb_rd_addr_o        <= p_rd_addr;
                wb_misaligned_o     <= 1'b0;
            end
        end
    end

    assign wb_rf_wr_en_o = wb_rf_wr_en_q && wb_valid_o && !wb_misaligned_o;

endmodule
